// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver.
//   state_e        : receiver FSM states (IDLE / ALIGN / RECV)
//   LEFT / RIGHT   : channel encodings, matching the lrclk level
//   DEFAULT_DATA_W : default channel word width
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RECV  = 2'd2
  } state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam int unsigned DEFAULT_DATA_W = 24;

endpackage

// File: rtl/i2s_edge_detect.sv
// Word-select change detector.
// Registers lrclk every sclk rising edge; lr_edge is high whenever the
// currently sampled lrclk differs from the registered copy.
// Ports:
//   sclk    in  : bit clock
//   rst     in  : asynchronous active-low reset (registered copy clears to 0)
//   lrclk   in  : word select
//   lr_edge out : lrclk change seen at this rising edge
module i2s_edge_detect (
  input  logic sclk,
  input  logic rst,
  input  logic lrclk,
  output logic lr_edge
);

  logic prev_lr;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      prev_lr <= 1'b0;
    end else begin
      prev_lr <= lrclk;
    end
  end

  assign lr_edge = lrclk ^ prev_lr;

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: deserialises MSB-first channel words from sdin and presents
// them as left/right pairs. A pair is only presented when a complete left word
// is followed by a complete right word; valid pulses for one sclk cycle.
//
// Optional feature (macro I2S_RX_FRAME_CHECK_EN): adds the sticky frame_err
// output, set whenever an lrclk change cuts a word short. Without the macro
// the port and its logic are absent and aborts are silent.
//
// Parameters:
//   DATA_W    : bits per channel word (8..31)
//   MSB_DELAY : sclk rising edges from lrclk-change detection to MSB sample (1..3)
// Ports:
//   sclk       in  : bit clock, only clock, rising edge
//   rst        in  : asynchronous active-low reset
//   lrclk      in  : word select, 0 = left, 1 = right
//   sdin       in  : serial data, MSB first
//   left_data  out : last complete left word (signed)
//   right_data out : last complete right word (signed)
//   valid      out : one-cycle pulse when a new pair is presented
//   frame_err  out : sticky short-frame flag (only with I2S_RX_FRAME_CHECK_EN)
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned MSB_DELAY = 2
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     lrclk,
  input  logic                     sdin,
  output logic signed [DATA_W-1:0] left_data,
  output logic signed [DATA_W-1:0] right_data,
  output logic                     valid
`ifdef I2S_RX_FRAME_CHECK_EN
  ,
  output logic                     frame_err
`endif
);

  localparam int unsigned CntW       = $clog2(DATA_W);
  localparam logic [1:0]  DlyInit    = 2'(MSB_DELAY - 1);
  // With a one-cycle delay the MSB arrives on the very next edge, so ALIGN is skipped.
  localparam state_e      StartState = (MSB_DELAY == 1) ? RECV : ALIGN;

  logic              lr_edge;
  state_e            state_q, state_d;
  logic              chan_q;
  logic [1:0]        dly_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] word;
  logic              have_left_q;
  logic [DATA_W-1:0] left_q, right_q;
  logic              valid_q;

  // Control strobes decoded from the FSM
  logic abort, dly_dec, shift_en, commit, load_bits;

  i2s_edge_detect u_edge_detect (
    .sclk    (sclk),
    .rst     (rst),
    .lrclk   (lrclk),
    .lr_edge (lr_edge)
  );

  // Word as it stands once the bit sampled on this edge is shifted in.
  assign word = {shift_q[DATA_W-2:0], sdin};

  // State register
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an lrclk change restarts alignment from any state.
  always_comb begin
    state_d = state_q;
    if (lr_edge) begin
      state_d = StartState;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ALIGN:   if (dly_q == 2'd1) state_d = RECV;
        RECV:    if (bit_cnt_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/strobe decode
  always_comb begin
    abort     = lr_edge && (state_q != IDLE);
    dly_dec   = !lr_edge && (state_q == ALIGN);
    shift_en  = !lr_edge && (state_q == RECV);
    commit    = shift_en && (bit_cnt_q == '0);
    load_bits = lr_edge ? (MSB_DELAY == 1) : (dly_dec && (dly_q == 2'd1));
  end

  // Datapath
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      chan_q      <= LEFT;
      dly_q       <= 2'd0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      have_left_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if (lr_edge) begin
        chan_q <= lrclk;
        dly_q  <= DlyInit;
      end else if (dly_dec) begin
        dly_q <= dly_q - 2'd1;
      end

      if (load_bits) begin
        bit_cnt_q <= CntW'(DATA_W - 1);
      end else if (shift_en && !commit) begin
        bit_cnt_q <= bit_cnt_q - CntW'(1);
      end

      if (shift_en) begin
        shift_q <= word;
      end

      // A cut-short left word must not pair with the following right word.
      if (abort && (chan_q == LEFT)) begin
        have_left_q <= 1'b0;
      end

      if (commit) begin
        if (chan_q == LEFT) begin
          hold_q      <= word;
          have_left_q <= 1'b1;
        end else if ((chan_q == RIGHT) && have_left_q) begin
          left_q      <= hold_q;
          right_q     <= word;
          valid_q     <= 1'b1;
          have_left_q <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  logic frame_err_q;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else if (abort) begin
      frame_err_q <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign left_data  = left_q;
  assign right_data = right_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver. Two instances share sclk, rst and
// lrclk: dut0 uses MSB_DELAY=2, dut1 uses MSB_DELAY=1, each with its own sdin
// timed to match. Expected pairs are queued when a right slot's LSB is driven
// and checked (data and arrival cycle) when valid pulses.
module tb_i2s_receiver;

  logic sclk;
  logic rst;
  logic lrclk;
  logic sdin0, sdin1;
  logic signed [23:0] left_data0, right_data0, left_data1, right_data1;
  logic valid0, valid1;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic frame_err0, frame_err1;
`endif

  i2s_receiver #(
    .DATA_W    (24),
    .MSB_DELAY (2)
  ) dut0 (
    .sclk       (sclk),
    .rst        (rst),
    .lrclk      (lrclk),
    .sdin       (sdin0),
    .left_data  (left_data0),
    .right_data (right_data0),
    .valid      (valid0)
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    .frame_err  (frame_err0)
`endif
  );

  i2s_receiver #(
    .DATA_W    (24),
    .MSB_DELAY (1)
  ) dut1 (
    .sclk       (sclk),
    .rst        (rst),
    .lrclk      (lrclk),
    .sdin       (sdin1),
    .left_data  (left_data1),
    .right_data (right_data1),
    .valid      (valid1)
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    .frame_err  (frame_err1)
`endif
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          cyc;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  exp_t e0, e1;
  int   cyc;
  int   checks;
  int   passes;

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Scoreboard: pop and compare whenever a DUT presents a pair.
  always begin
    @(posedge sclk);
    cyc = cyc + 1;
    #1;
    if (valid0) begin
      if (exp0.size() == 0) begin
        checks++;
        $display("FAIL dut0_unexpected_valid: got valid=1 at cycle %0d, required none", cyc);
      end else begin
        e0 = exp0.pop_front();
        checks += 3;
        if (left_data0 !== e0.l) $display("FAIL dut0_left: got %h required %h", left_data0, e0.l);
        else passes++;
        if (right_data0 !== e0.r) $display("FAIL dut0_right: got %h required %h", right_data0, e0.r);
        else passes++;
        if (cyc !== e0.cyc) $display("FAIL dut0_latency: got cycle %0d required %0d", cyc, e0.cyc);
        else passes++;
      end
    end
    if (valid1) begin
      if (exp1.size() == 0) begin
        checks++;
        $display("FAIL dut1_unexpected_valid: got valid=1 at cycle %0d, required none", cyc);
      end else begin
        e1 = exp1.pop_front();
        checks += 3;
        if (left_data1 !== e1.l) $display("FAIL dut1_left: got %h required %h", left_data1, e1.l);
        else passes++;
        if (right_data1 !== e1.r) $display("FAIL dut1_right: got %h required %h", right_data1, e1.r);
        else passes++;
        if (cyc !== e1.cyc) $display("FAIL dut1_latency: got cycle %0d required %0d", cyc, e1.cyc);
        else passes++;
      end
    end
  end

  // One channel slot of len sclks, lrclk changing on the first falling edge.
  // When push is set this is the right slot of a pair that must be presented.
  task automatic send_slot(input logic ch, input logic [23:0] w, input int len,
                           input logic fill, input logic push, input logic [23:0] lw);
    exp_t e;
    for (int j = 0; j < len; j++) begin
      @(negedge sclk);
      lrclk = ch;
      sdin0 = (j >= 2 && j < 26) ? w[25 - j] : fill;
      sdin1 = (j >= 1 && j < 25) ? w[24 - j] : fill;
      if (push && j == 25) begin
        e.l = lw; e.r = w; e.cyc = cyc + 1;
        exp0.push_back(e);
      end
      if (push && j == 24) begin
        e.l = lw; e.r = w; e.cyc = cyc + 1;
        exp1.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic fill,
                            input logic push);
    send_slot(1'b0, l, 32, fill, 1'b0, 24'h0);
    send_slot(1'b1, r, 32, fill, push, l);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge sclk);
      sdin0 = 1'($urandom());
      sdin1 = 1'($urandom());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; lrclk = 1'b1; sdin0 = 1'b0; sdin1 = 1'b0;
    #12;
    checks += 6;
    if (left_data0 !== 24'h0) $display("FAIL reset_left0: got %h required 000000", left_data0);
    else passes++;
    if (right_data0 !== 24'h0) $display("FAIL reset_right0: got %h required 000000", right_data0);
    else passes++;
    if (valid0 !== 1'b0) $display("FAIL reset_valid0: got %b required 0", valid0);
    else passes++;
    if (left_data1 !== 24'h0) $display("FAIL reset_left1: got %h required 000000", left_data1);
    else passes++;
    if (right_data1 !== 24'h0) $display("FAIL reset_right1: got %h required 000000", right_data1);
    else passes++;
    if (valid1 !== 1'b0) $display("FAIL reset_valid1: got %b required 0", valid1);
    else passes++;
`ifdef I2S_RX_FRAME_CHECK_EN
    checks += 2;
    if (frame_err0 !== 1'b0) $display("FAIL reset_frame_err0: got %b required 0", frame_err0);
    else passes++;
    if (frame_err1 !== 1'b0) $display("FAIL reset_frame_err1: got %b required 0", frame_err1);
    else passes++;
`endif
    @(negedge sclk);
    rst = 1'b1;
    idle(30);
  endtask

  task automatic check_drained(input string name);
    checks += 2;
    if (exp0.size() != 0) $display("FAIL %s_missing0: got %0d pending required 0", name, exp0.size());
    else passes++;
    if (exp1.size() != 0) $display("FAIL %s_missing1: got %0d pending required 0", name, exp1.size());
    else passes++;
    exp0.delete();
    exp1.delete();
  endtask

  task automatic test_loopback();
    send_frame(24'h123456, 24'hFEDCBA, 1'b0, 1'b1);
    send_frame(24'h123456, 24'hFEDCBA, 1'b0, 1'b1);
    send_frame(24'h0A0B0C, 24'h7FFFFF, 1'b0, 1'b1);
    idle(4);
    check_drained("loopback");
  endtask

  task automatic test_negative();
    send_frame(24'h800000, 24'hFFFFFF, 1'b0, 1'b1);
    idle(4);
    checks += 4;
    if (int'(left_data0) != -8388608) $display("FAIL neg_left0: got %0d required -8388608", left_data0);
    else passes++;
    if (int'(right_data0) != -1) $display("FAIL neg_right0: got %0d required -1", right_data0);
    else passes++;
    if (int'(left_data1) != -8388608) $display("FAIL neg_left1: got %0d required -8388608", left_data1);
    else passes++;
    if (int'(right_data1) != -1) $display("FAIL neg_right1: got %0d required -1", right_data1);
    else passes++;
    check_drained("negative");
  endtask

  task automatic test_trailing_bits();
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b1);
    send_frame(24'h000001, 24'h100000, 1'b1, 1'b1);
    idle(4);
    check_drained("trailing");
  endtask

  task automatic test_msb_delay1();
    send_frame(24'h00000F, 24'hABCDEF, 1'b0, 1'b1);
    idle(4);
    checks++;
    if (left_data1 !== 24'h00000F) $display("FAIL delay1_left: got %h required 00000f", left_data1);
    else passes++;
    check_drained("msb_delay1");
  endtask

  task automatic test_reset_mid_word();
    send_slot(1'b0, 24'h111111, 32, 1'b0, 1'b0, 24'h0);
    send_slot(1'b1, 24'h222222, 10, 1'b0, 1'b0, 24'h0);
    @(negedge sclk);
    rst = 1'b0;
    #2;
    checks += 4;
    if (left_data0 !== 24'h0) $display("FAIL midrst_left0: got %h required 000000", left_data0);
    else passes++;
    if (right_data0 !== 24'h0) $display("FAIL midrst_right0: got %h required 000000", right_data0);
    else passes++;
    if (left_data1 !== 24'h0) $display("FAIL midrst_left1: got %h required 000000", left_data1);
    else passes++;
    if (right_data1 !== 24'h0) $display("FAIL midrst_right1: got %h required 000000", right_data1);
    else passes++;
    repeat (3) @(negedge sclk);
    rst = 1'b1;
    idle(30);
    send_frame(24'h13579B, 24'h2468AC, 1'b0, 1'b1);
    idle(4);
    check_drained("reset_mid");
  endtask

  task automatic test_abort();
`ifdef I2S_RX_FRAME_CHECK_EN
    checks += 2;
    if (frame_err0 !== 1'b0) $display("FAIL pre_abort_err0: got %b required 0", frame_err0);
    else passes++;
    if (frame_err1 !== 1'b0) $display("FAIL pre_abort_err1: got %b required 0", frame_err1);
    else passes++;
`endif
    // Complete left, glitch to right, then a left cut after 10 bits: the
    // held left word must be dropped so the following right is discarded.
    send_slot(1'b0, 24'h777777, 32, 1'b0, 1'b0, 24'h0);
    send_slot(1'b1, 24'h0, 2, 1'b0, 1'b0, 24'h0);
    send_slot(1'b0, 24'hCAFE12, 12, 1'b0, 1'b0, 24'h0);
    send_slot(1'b1, 24'h345678, 32, 1'b0, 1'b0, 24'h0);
`ifdef I2S_RX_FRAME_CHECK_EN
    checks += 2;
    if (frame_err0 !== 1'b1) $display("FAIL abort_err0: got %b required 1", frame_err0);
    else passes++;
    if (frame_err1 !== 1'b1) $display("FAIL abort_err1: got %b required 1", frame_err1);
    else passes++;
`endif
    send_frame(24'h0FF0F0, 24'h5A5A5A, 1'b0, 1'b1);
    idle(4);
    check_drained("abort");
  endtask

  task automatic test_back_to_back();
    logic [23:0] l, r;
    for (int i = 0; i < 4; i++) begin
      l = 24'($urandom());
      r = 24'($urandom());
      send_frame(l, r, 1'(i), 1'b1);
    end
    idle(4);
    check_drained("back_to_back");
  endtask

  initial begin
    cyc = 0; checks = 0; passes = 0;
    test_reset();
    test_loopback();
    test_negative();
    test_trailing_bits();
    test_msb_delay1();
    test_reset_mid_word();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
